// File: rtl/analog_status_pkg.sv
// analog_status_pkg: shared types and constants for the analog status poller
package analog_status_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, WAIT} poll_state_e;
    localparam int APB_WORD_STRIDE = 4;
endpackage

// File: rtl/analog_status_poller_apb_read_initiator.sv
// apb_read_initiator: single APB read handshake (SETUP/ACCESS) with an ACCESS-phase timeout
module apb_read_initiator #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              psel_o,
    output logic              penable_o,
    output logic [ADDR_W-1:0] paddr_o,
    input  logic [31:0]       prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i,
    output logic              done_o,
    output logic [31:0]       data_o,
    output logic              err_o,
    output logic              timeout_o
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic              psel_q;
    logic              penable_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [TW-1:0]     tcnt_q;
    logic              access;

    assign access    = psel_q && penable_q;
    assign timeout_o = access && !pready_i && tcnt_q == TW'(TIMEOUT - 1);
    assign done_o    = access && (pready_i || timeout_o);
    assign err_o     = access && pready_i && pslverr_i;
    assign data_o    = prdata_i;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign paddr_o   = paddr_q;

    // A request in the completing cycle chains straight into the next SETUP
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            tcnt_q    <= '0;
        end else begin
            psel_q    <= req_i || (psel_q && !done_o);
            penable_q <= psel_q && !done_o;
            paddr_q   <= req_i ? addr_i : paddr_q;
            tcnt_q    <= (access && !done_o) ? tcnt_q + 1'b1 : '0;
        end
    end
endmodule

// File: rtl/analog_status_poller.sv
// analog_status_poller: sweeps the analog status bank over APB into a snapshot,
// flagging changed or failed words through a level interrupt
module analog_status_poller
    import analog_status_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                NUM_REGS  = 4,
    parameter int                POLL_DIV  = 1024,
    parameter int                TIMEOUT   = 64
) (
    input  logic                     clk_in,
    input  logic                     reset_n,
    output logic [ADDR_W-1:0]        PADDR,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [31:0]              PWDATA,
    output logic [3:0]               PSTRB,
    input  logic [31:0]              PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR,
    input  logic                     enable,
    input  logic                     start_single,
    input  logic                     irq_clear,
    output logic [NUM_REGS*32-1:0]   snapshot,
    output logic                     snapshot_valid,
    output logic [NUM_REGS-1:0]      change_mask,
    output logic [NUM_REGS-1:0]      err_mask,
    output logic                     sweep_done,
    output logic                     busy,
    output logic                     irq
);
    localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam int CW = POLL_DIV > 1 ? $clog2(POLL_DIV) : 1;

    poll_state_e                state_q;
    logic [IW-1:0]              idx_q;
    logic [IW-1:0]              idx_d;
    logic [CW-1:0]              cnt_q;
    logic [NUM_REGS-1:0][31:0]  snap_q;
    logic                       valid_q;
    logic                       done_q;
    logic [NUM_REGS-1:0]        chg_q;
    logic [NUM_REGS-1:0]        err_q;
    logic [NUM_REGS-1:0]        hit;
    logic [NUM_REGS-1:0]        chg_set;
    logic [NUM_REGS-1:0]        err_set;
    logic                       req;
    logic                       last;
    logic                       good;
    logic                       xfer_done;
    logic                       xfer_err;
    logic                       xfer_to;
    logic [31:0]                xfer_data;
    logic [ADDR_W-1:0]          req_addr;

    apb_read_initiator #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_apb (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .req_i     (req),
        .addr_i    (req_addr),
        .psel_o    (PSEL),
        .penable_o (PENABLE),
        .paddr_o   (PADDR),
        .prdata_i  (PRDATA),
        .pready_i  (PREADY),
        .pslverr_i (PSLVERR),
        .done_o    (xfer_done),
        .data_o    (xfer_data),
        .err_o     (xfer_err),
        .timeout_o (xfer_to)
    );

    always_comb begin
        last     = idx_q == IW'(NUM_REGS - 1);
        req      = (state_q == IDLE && (enable || start_single)) ||
                   (state_q == WAIT && enable && cnt_q == '0) ||
                   (state_q == ACCESS && xfer_done && !last);
        idx_d    = state_q == ACCESS ? idx_q + 1'b1 : '0;
        req_addr = BASE_ADDR + ADDR_W'(APB_WORD_STRIDE) * ADDR_W'(idx_d);
        hit      = NUM_REGS'(1) << idx_q;
        good     = xfer_done && !xfer_err && !xfer_to;
        chg_set  = (good && valid_q && xfer_data != snap_q[idx_q]) ? hit : '0;
        err_set  = (xfer_err || xfer_to) ? hit : '0;
    end

    // New flag events are OR-ed in after the clear so they survive a coincident irq_clear
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            chg_q   <= '0;
            err_q   <= '0;
        end else begin
            done_q <= state_q == ACCESS && xfer_done && last;
            chg_q  <= (chg_q & ~{NUM_REGS{irq_clear}}) | chg_set;
            err_q  <= (err_q & ~{NUM_REGS{irq_clear}}) | err_set;
            if (req)
                idx_q <= idx_d;
            if (good)
                snap_q[idx_q] <= xfer_data;
            case (state_q)
                IDLE:    state_q <= req ? SETUP : IDLE;
                SETUP:   state_q <= ACCESS;
                ACCESS: begin
                    if (xfer_done && !last)
                        state_q <= SETUP;
                    else if (xfer_done) begin
                        valid_q <= 1'b1;
                        cnt_q   <= CW'(POLL_DIV - 1);
                        state_q <= enable ? WAIT : IDLE;
                    end
                end
                WAIT: begin
                    cnt_q   <= cnt_q - 1'b1;
                    state_q <= !enable ? IDLE : (cnt_q == '0 ? SETUP : WAIT);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PWRITE         = 1'b0;
    assign PWDATA         = '0;
    assign PSTRB          = '0;
    assign snapshot       = snap_q;
    assign snapshot_valid = valid_q;
    assign change_mask    = chg_q;
    assign err_mask       = err_q;
    assign sweep_done     = done_q;
    assign busy           = state_q == SETUP || state_q == ACCESS;
    assign irq            = |{chg_q, err_q};
endmodule
